pixel_besleyici: RTL
====================

# pixel_besleyici

- Streams a stored image from the image SRAM into the task unit as a pixel stream.
- Accepts a job command (task code), pulses the task unit's start strobe with the task code, then reads GENISLIK×YUKSEKLIK pixels in raster order and presents them one per cycle on the task unit's valid/pixel inputs.
- Inserts a programmable idle gap between rows, honours a pause input, and pulses a done flag after the last pixel leaves.
- Sits between the image SRAM read port and the task unit's input side.

## Interface
- GENISLIK, 128: pixels per row.
- YUKSEKLIK, 128: rows per frame.
- ADR_BIT, 14: SRAM address width; must satisfy 2^ADR_BIT ≥ GENISLIK·YUKSEKLIK.
- ARA, 2: idle cycles between rows (0 allowed).
- PIXEL_BIT, 8: pixel width.
- GRV_BIT, 3: task code width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low.
- komut_gecerli_i  in  1  job command valid.
- komut_gorev_i  in  GRV_BIT  task code for the job.
- komut_hazir_o  out  1  block can accept a command.
- durdur_i  in  1  pause; no new SRAM read is issued while high.
- mem_csb_o  out  1  SRAM read chip-select, active low.
- mem_adr_o  out  ADR_BIT  SRAM read address.
- mem_veri_i  in  PIXEL_BIT  SRAM read data; valid one cycle after a read with csb=0.
- basla_o  out  1  one-cycle start strobe to the task unit.
- gorev_o  out  GRV_BIT  task code; held for the whole job.
- etkin_o  out  1  pixel valid to the task unit.
- pixel_o  out  PIXEL_BIT  pixel to the task unit.
- bitti_o  out  1  one-cycle pulse when the last pixel has been presented.

## Operation
- **Handshake.** A command is accepted on a rising edge where komut_gecerli_i && komut_hazir_o. komut_hazir_o is 1 only in BOSTA.
- **BOSTA**
  - Outputs idle: mem_csb_o=1, etkin_o=0.
  - On command accept: latch komut_gorev_i into gorev_o, clear the column/row/address counters, go to BASLA.
- **BASLA** (exactly 1 cycle)
  - basla_o=1; no read is issued.
  - Next state is OKU.
- **OKU**
  - Each cycle with durdur_i=0: mem_csb_o=0, mem_adr_o=address counter. Then increment the address and column counters.
  - With durdur_i=1: mem_csb_o=1 and the counters hold.
  - Column wraps GENISLIK-1 → 0:
    - if this was the last row, go to SON;
    - else if ARA>0, go to ARA;
    - else stay in OKU. The row counter increments either way.
- **ARA**
  - mem_csb_o=1 for ARA cycles (down-counter), then back to OKU.
  - durdur_i does not extend the gap.
- **SON**
  - No reads; wait until the pipeline is empty.
  - In the cycle the last pixel is presented (etkin_o=1), assert bitti_o=1.
  - Next state is BOSTA. gorev_o keeps its value until the next command.
- **Data pipeline**
  - A read issued at cycle t produces mem_veri_i at t+1.
  - At the t+2 edge, pixel_o ← mem_veri_i and etkin_o ← 1.
  - A 2-bit shift register tracks in-flight reads and drives etkin_o.
  - pixel_o holds its last value when etkin_o=0.
- **Address.** Linear 0..GENISLIK·YUKSEKLIK-1 and never wraps within a job.
- **Commands while busy** are ignored (hazir=0) and not queued.

## Timing
- **Reset values** (asynchronous assertion, synchronous release): state=BOSTA, komut_hazir_o=1, mem_csb_o=1, mem_adr_o=0, basla_o=0, gorev_o=0, etkin_o=0, pixel_o=0, bitti_o=0, all counters 0.
- **Reset mid-job** aborts immediately. In-flight data is discarded, bitti_o is not pulsed, and the next command starts from address 0.
- **Command-to-stream latency:**
  - accept edge at cycle 0;
  - basla_o high during cycle 1;
  - first read (adr 0) during cycle 2;
  - first etkin_o=1 in cycle 4.
- **Throughput** is 1 pixel/cycle within a row when durdur_i=0.
- **Row gaps.** Each row boundary gives exactly ARA idle cycles on etkin_o, plus any cycles lost to durdur_i.
- **Pause.** durdur_i raised at cycle t blocks the read in cycle t. Reads from t-1 and t-2 still emerge, so etkin_o stays high up to 2 cycles after pause.
- **Last pixel.** bitti_o coincides with etkin_o of the last pixel. komut_hazir_o=1 from the next cycle.
- **Minimum command spacing:** GENISLIK·YUKSEKLIK + (YUKSEKLIK-1)·ARA + 4 cycles.

## Test plan
- **Basic frame.** GENISLIK=4, YUKSEKLIK=2, ARA=0; SRAM[i]=i+10; command gorev=3 at cycle 0.
  - basla_o at cycle 1.
  - etkin_o high cycles 4–11 with pixels 10..17.
  - bitti_o at cycle 11; hazir_o=1 at cycle 12.
- **Row gap.** Same image, ARA=2.
  - Pixels 10–13 on cycles 4–7, idle cycles 8–9, pixels 14–17 on cycles 10–13.
  - bitti_o at cycle 13.
- **Pause.** ARA=0, durdur_i=1 during cycles 4–6.
  - Exactly 8 pixels, in order, none duplicated.
  - etkin_o low for exactly 3 cycles mid-stream; last pixel at cycle 14.
- **Busy command.** Second command (gorev=5) asserted during streaming.
  - Ignored; gorev_o stays 3; no second basla_o.
  - Command presented after bitti_o is accepted.
- **Reset mid-job.** rstn_i low for 1 cycle at cycle 6.
  - All outputs return to reset values asynchronously; no bitti_o.
  - A new command restarts at mem_adr_o=0.
- **Back-to-back jobs.** Command held valid continuously.
  - Two jobs run with exactly one BOSTA cycle between bitti_o and the second accept.
  - gorev_o switches only on the accept edge.

Source files
------------

// File: rtl/pixel_besleyici.sv
// pixel_besleyici: streams a stored image from the image SRAM into the task unit.
// A command starts the job: one start strobe, then a raster-order SRAM read sweep
// with optional idle gaps between rows. Pixels emerge two cycles after each read.
module pixel_besleyici #(
  parameter int GENISLIK  = 128,
  parameter int YUKSEKLIK = 128,
  parameter int ADR_BIT   = 14,
  parameter int ARA       = 2,
  parameter int PIXEL_BIT = 8,
  parameter int GRV_BIT   = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 komut_gecerli_i,
  input  logic [GRV_BIT-1:0]   komut_gorev_i,
  output logic                 komut_hazir_o,
  input  logic                 durdur_i,
  output logic                 mem_csb_o,
  output logic [ADR_BIT-1:0]   mem_adr_o,
  input  logic [PIXEL_BIT-1:0] mem_veri_i,
  output logic                 basla_o,
  output logic [GRV_BIT-1:0]   gorev_o,
  output logic                 etkin_o,
  output logic [PIXEL_BIT-1:0] pixel_o,
  output logic                 bitti_o
);

  localparam int CW = (GENISLIK  > 1) ? $clog2(GENISLIK)  : 1;
  localparam int RW = (YUKSEKLIK > 1) ? $clog2(YUKSEKLIK) : 1;
  localparam int GW = (ARA       > 1) ? $clog2(ARA)       : 1;
  localparam logic [CW-1:0] SUTUN_SON = CW'(GENISLIK - 1);
  localparam logic [RW-1:0] SATIR_SON = RW'(YUKSEKLIK - 1);
  // Gap counter counts down to zero, so it is loaded with ARA-1.
  localparam logic [GW-1:0] ARA_YUK   = GW'((ARA > 0) ? ARA - 1 : 0);

  typedef enum logic [2:0] {S_BOSTA, S_BASLA, S_OKU, S_ARA, S_SON} durum_t;

  durum_t              durum, durum_d;
  logic [CW-1:0]       sutun;
  logic [RW-1:0]       satir;
  logic [ADR_BIT-1:0]  adr;
  logic [GW-1:0]       ara_say;
  // [0]: read issued last cycle (data on mem_veri_i now); [1]: pixel_o valid.
  logic [1:0]          vld_pipe;
  logic                oku;
  logic                kabul;
  logic                sutun_son;
  logic                satir_son;

  assign kabul     = komut_gecerli_i && (durum == S_BOSTA);
  assign sutun_son = (sutun == SUTUN_SON);
  assign satir_son = (satir == SATIR_SON);

  assign mem_csb_o = ~oku;
  assign mem_adr_o = adr;
  assign etkin_o   = vld_pipe[1];

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) durum <= S_BOSTA;
    else         durum <= durum_d;
  end

  // Next-state and per-state outputs; reads are blocked combinationally by pause.
  always_comb begin
    durum_d       = durum;
    oku           = 1'b0;
    basla_o       = 1'b0;
    komut_hazir_o = 1'b0;
    bitti_o       = 1'b0;
    case (durum)
      S_BOSTA: begin
        komut_hazir_o = 1'b1;
        if (komut_gecerli_i) durum_d = S_BASLA;
      end
      S_BASLA: begin
        basla_o = 1'b1;
        durum_d = S_OKU;
      end
      S_OKU: begin
        if (!durdur_i) begin
          oku = 1'b1;
          if (sutun_son) begin
            if (satir_son)    durum_d = S_SON;
            else if (ARA > 0) durum_d = S_ARA;
            else              durum_d = S_OKU;
          end
        end
      end
      S_ARA: begin
        if (ara_say == '0) durum_d = S_OKU;
      end
      S_SON: begin
        // Last pixel is on the output and nothing is behind it.
        if (vld_pipe[1] && !vld_pipe[0]) begin
          bitti_o = 1'b1;
          durum_d = S_BOSTA;
        end
      end
      default: durum_d = S_BOSTA;
    endcase
  end

  // Job setup, raster counters and row-gap down-counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sutun   <= '0;
      satir   <= '0;
      adr     <= '0;
      ara_say <= '0;
      gorev_o <= '0;
    end else begin
      if (kabul) begin
        sutun   <= '0;
        satir   <= '0;
        adr     <= '0;
        gorev_o <= komut_gorev_i;
      end
      if (oku) begin
        adr <= adr + 1'b1;
        if (sutun_son) begin
          sutun   <= '0;
          satir   <= satir + 1'b1;
          ara_say <= ARA_YUK;
        end else begin
          sutun <= sutun + 1'b1;
        end
      end else if (durum == S_ARA && ara_say != '0) begin
        ara_say <= ara_say - 1'b1;
      end
    end
  end

  // Read-tracking shift register and pixel capture; pixel_o holds when idle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_pipe <= '0;
      pixel_o  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], oku};
      if (vld_pipe[0]) pixel_o <= mem_veri_i;
    end
  end

endmodule
